// File: rtl/pll_step_ctrl_pkg.sv
// Shared types and constants for the PLL frequency-step controller.
// The FSM state encoding lives here so that checkers can bind to it.
package pll_step_pkg;

  localparam int POS_W = 4;
  localparam logic [POS_W-1:0] POS_MAX_DEF  = 4'd10;
  localparam logic [POS_W-1:0] POS_INIT_DEF = 4'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    RECONF    = 2'd3
  } state_t;

  // Four-digit BCD increment; 9999 rolls over to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_step_ctrl_if.sv
// Link between the step controller and the PLL reconfiguration engine.
// Handshake: write_from_rom, reconfig and reconfig_reset are one-cycle pulses from
// the controller; reconfig is only issued when reconfig_busy is low, and the end
// of a reconfiguration is signalled by reconfig_busy returning low.
interface pll_step_ctrl_if;
  logic reconfig_busy;
  logic write_from_rom;
  logic reconfig;
  logic reconfig_reset;

  modport master (
    input  reconfig_busy,
    output write_from_rom,
    output reconfig,
    output reconfig_reset
  );

  modport slave (
    output reconfig_busy,
    input  write_from_rom,
    input  reconfig,
    input  reconfig_reset
  );
endinterface

// File: rtl/pll_step_ctrl_bcd_timer.sv
// Elapsed-time counters: mins in 4-digit BCD, secs as binary 100 ms ticks.
// clr holds everything (including the visible outputs) at zero.
module bcd_timer #(
  parameter logic [31:0] TICK_DIV = 32'd5_000_000,
  parameter logic [31:0] MIN_DIV  = 32'd3_000_000_000
) (
  input  logic        clock_50_i,
  input  logic        RESET,
  input  logic        clr,
  output logic [15:0] mins,
  output logic [15:0] secs
);
  import pll_step_pkg::*;

  logic [31:0] tick_cnt;
  logic [31:0] min_cnt;
  logic [15:0] mins_q;
  logic [15:0] secs_q;

  always_ff @(posedge clock_50_i) begin
    if (RESET || clr) begin
      tick_cnt <= '0;
      min_cnt  <= '0;
      mins_q   <= '0;
      secs_q   <= '0;
    end else begin
      if (tick_cnt == TICK_DIV - 32'd1) begin
        tick_cnt <= '0;
        secs_q   <= secs_q + 16'd1;
      end else begin
        tick_cnt <= tick_cnt + 32'd1;
      end
      if (min_cnt == MIN_DIV - 32'd1) begin
        min_cnt <= '0;
        mins_q  <= bcd_inc(mins_q);
      end else begin
        min_cnt <= min_cnt + 32'd1;
      end
    end
  end

  // Gate the outputs so they read zero from the first cycle clr is high.
  assign mins = clr ? 16'd0 : mins_q;
  assign secs = clr ? 16'd0 : secs_q;

endmodule

// File: rtl/pll_step_ctrl.sv
// PLL frequency stepping controller: buttons / auto sweep choose a ROM index and
// a small FSM sequences the reconfiguration engine. Define PLL_STEP_AUTO_EN for auto sweep.
module pll_step_ctrl
  import pll_step_pkg::*;
#(
  parameter logic [POS_W-1:0] POS_MAX  = POS_MAX_DEF,
  parameter logic [POS_W-1:0] POS_INIT = POS_INIT_DEF,
  parameter int unsigned      TIMEOUT  = 1000,
  parameter logic [31:0]      TICK_DIV = 32'd5_000_000,
  parameter logic [31:0]      MIN_DIV  = 32'd3_000_000_000
) (
  input  logic              clock_50_i,
  input  logic              RESET,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_auto,
  input  logic              auto_start,
  input  logic              pass_seen,
  input  logic              fail_seen,
  pll_step_ctrl_if.master   rcfg,
  output logic [POS_W-1:0]  pos,
  output logic              auto,
  output logic              recfg,
  output logic [15:0]       mins,
  output logic [15:0]       secs,
  output state_t            state_dbg
);

  state_t            state;
  logic [POS_W-1:0]  pos_q;
  logic              auto_q;
  logic              recfg_q;
  logic              wfr_q, rc_q, rr_q;
  logic [31:0]       timer;
  logic [31:0]       timer_dec;
  logic              btn_up_q, btn_down_q;
  logic              up_ev, down_ev, auto_ev, start_ev, adv_ev, pass_fail;

  assign up_ev     = btn_up & ~btn_up_q;
  assign down_ev   = btn_down & ~btn_down_q;
  assign timer_dec = timer - 32'd1;

`ifdef PLL_STEP_AUTO_EN
  logic btn_auto_q;
  always_ff @(posedge clock_50_i) begin
    if (RESET) btn_auto_q <= 1'b0;
    else       btn_auto_q <= btn_auto;
  end
  assign auto_ev   = btn_auto & ~btn_auto_q;
  assign start_ev  = auto_start;
  assign pass_fail = pass_seen & fail_seen;
`else
  logic unused_auto_in;
  assign unused_auto_in = &{1'b0, btn_auto, auto_start, pass_seen, fail_seen};
  assign auto_ev   = 1'b0;
  assign start_ev  = 1'b0;
  assign pass_fail = 1'b0;
`endif

  assign adv_ev = auto_q & pass_fail & ~recfg_q & (pos_q < POS_MAX);

  always_ff @(posedge clock_50_i) begin
    if (RESET) begin
      state      <= IDLE;
      pos_q      <= POS_INIT;
      auto_q     <= 1'b0;
      recfg_q    <= 1'b0;
      wfr_q      <= 1'b0;
      rc_q       <= 1'b0;
      rr_q       <= 1'b0;
      timer      <= '0;
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
    end else begin
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      wfr_q      <= 1'b0;
      rc_q       <= 1'b0;
      rr_q       <= 1'b0;

      case (state)
        IDLE: if (recfg_q) begin
          wfr_q <= 1'b1;
          state <= LOAD;
        end
        LOAD: state <= WAIT_BUSY;
        WAIT_BUSY: if (!rcfg.reconfig_busy) begin
          rc_q  <= 1'b1;
          timer <= TIMEOUT;
          state <= RECONF;
        end
        RECONF: begin
          timer <= timer_dec;
          // rc_q is high only in the first RECONF cycle, before the engine can raise busy.
          if (timer_dec == 32'd1) begin
            rr_q    <= 1'b1;
            recfg_q <= 1'b0;
            state   <= IDLE;
          end else if (!rc_q && !rcfg.reconfig_busy) begin
            recfg_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Request events come last so a new request overrides a completion clear.
      if (start_ev) begin
        pos_q   <= '0;
        auto_q  <= 1'b1;
        recfg_q <= 1'b1;
      end else if (!recfg_q) begin
        if (adv_ev) begin
          pos_q   <= pos_q + POS_W'(1);
          recfg_q <= 1'b1;
        end else if (auto_ev) begin
          if (auto_q) begin
            auto_q <= 1'b0;
          end else begin
            pos_q  <= '0;
            auto_q <= 1'b1;
          end
          recfg_q <= 1'b1;
        end else if (down_ev) begin
          if (pos_q < POS_MAX) begin
            pos_q   <= pos_q + POS_W'(1);
            auto_q  <= 1'b0;
            recfg_q <= 1'b1;
          end
        end else if (up_ev) begin
          if (pos_q != '0) begin
            pos_q   <= pos_q - POS_W'(1);
            auto_q  <= 1'b0;
            recfg_q <= 1'b1;
          end
        end
      end
    end
  end

  bcd_timer #(
    .TICK_DIV (TICK_DIV),
    .MIN_DIV  (MIN_DIV)
  ) u_timer (
    .clock_50_i (clock_50_i),
    .RESET      (RESET),
    .clr        (recfg_q),
    .mins       (mins),
    .secs       (secs)
  );

  assign pos                 = pos_q;
  assign auto                = auto_q;
  assign recfg               = recfg_q;
  assign rcfg.write_from_rom = wfr_q;
  assign rcfg.reconfig       = rc_q;
  assign rcfg.reconfig_reset = rr_q;
  assign state_dbg           = state;

endmodule
